// File: rtl/toggle_cover_sched_if.sv
// toggle_cover_sched_if: output beat channel of the toggle-coverage scheduler.
// The scheduler (master) presents one absolute cover index per beat. The
// coverage reporter (slave) accepts it with out_ready.
interface toggle_cover_sched_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/toggle_cover_sched.sv
// toggle_cover_sched: accumulates per-bit toggle-coverage hit pulses into a
// pending bitmap. A round-robin arbiter drains the bitmap one absolute cover
// index per beat over a valid/ready port.
// Optional feature: define TOGGLE_COVER_STICKY_EN to report each bit at most
// once between resets/clears. A 'seen' mask is kept for this purpose.
module toggle_cover_sched #(
  parameter int WIDTH       = 35,
  parameter int COVER_INDEX = 0,
  parameter int CNT_W       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         valid,
  input  logic                     en,
  input  logic                     clear,
  toggle_cover_sched_if.master     out_if,
  output logic                     busy,
  output logic [CNT_W-1:0]         hit_count
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] grant_oh;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_found;
  logic             fire;
  logic             take;
  int               idx;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Round-robin start for the next search: one past the granted bit.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    if (g == PTR_W'(WIDTH - 1)) return '0;
    return g + 1'b1;
  endfunction

`ifdef TOGGLE_COVER_STICKY_EN
  logic [WIDTH-1:0] seen;

  assign new_hits = en ? (valid & ~seen) : '0;

  // Sticky mask: a bit is marked once it enters pending, until reset/clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      seen <= '0;
    else if (clear) seen <= '0;
    else            seen <= seen | new_hits;
  end
`else
  assign new_hits = en ? valid : '0;
`endif

  assign fire = out_if.out_valid && out_if.out_ready;
  // No grant in a clear cycle. Otherwise grant only if the output slot frees up.
  assign take = gnt_found && (!out_if.out_valid || out_if.out_ready) && !clear;
  assign busy = (|pending) || out_if.out_valid;

  // Arbiter: first pending bit at or after ptr, wrapping past WIDTH-1 to 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!gnt_found && pending[idx[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[PTR_W-1:0];
      end
    end
  end

  // One-hot of the bit actually handed to the output register this cycle.
  always_comb begin
    grant_oh = '0;
    if (take) grant_oh[gnt_idx] = 1'b1;
  end

  // Pending bitmap and pointer. A new sample of a granted bit wins and keeps it pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      ptr     <= '0;
    end else if (clear) begin
      pending <= '0;
      ptr     <= '0;
    end else begin
      pending <= (pending & ~grant_oh) | new_hits;
      if (take) ptr <= next_ptr(gnt_idx);
    end
  end

  // Output register: load on grant, drop on fire without grant, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_if.out_valid <= 1'b0;
      out_if.out_index <= '0;
    end else if (take) begin
      out_if.out_valid <= 1'b1;
      out_if.out_index <= 64'(COVER_INDEX) + 64'(gnt_idx);
    end else if (fire) begin
      out_if.out_valid <= 1'b0;
    end
  end

  // Count of transferred beats, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      hit_count <= '0;
    else if (clear) hit_count <= '0;
    else if (fire)  hit_count <= sat_inc(hit_count);
  end

endmodule

// File: tb/tb_toggle_cover_sched.sv
// tb_toggle_cover_sched: scoreboard bench for toggle_cover_sched.
// A behavioural model predicts the granted beats into a queue. A negedge
// monitor pops and compares on every transfer.
module tb_toggle_cover_sched;

  localparam int W    = 35;
  localparam int CI   = 100;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TOGGLE_COVER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [W-1:0]  tv;
  logic          en_r;
  logic          clear_r;
  logic          busy;
  logic [CW-1:0] hit_count;

  toggle_cover_sched_if bus ();

  toggle_cover_sched #(.WIDTH(W), .COVER_INDEX(CI), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (tv),
    .en        (en_r),
    .clear     (clear_r),
    .out_if    (bus),
    .busy      (busy),
    .hit_count (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int nbeats = 0;

  // Reference model state
  bit      m_pend [W];
  bit      m_seen [W];
  int      m_ptr;
  bit      m_v;
  int      m_cnt;
  longint  exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic bit m_busy();
    for (int i = 0; i < W; i++) if (m_pend[i]) return 1'b1;
    return m_v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_pend[i] = 1'b0;
      m_seen[i] = 1'b0;
    end
    m_ptr = 0;
    m_v   = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, from the inputs at that edge.
  task automatic model_step();
    bit fire;
    int g;
    bit nb [W];
    fire = m_v && bus.out_ready;
    for (int i = 0; i < W; i++) nb[i] = en_r && tv[i] && !(STICKY && m_seen[i]);
    if (clear_r) begin
      for (int i = 0; i < W; i++) begin
        m_pend[i] = 1'b0;
        m_seen[i] = 1'b0;
      end
      m_ptr = 0;
      m_cnt = 0;
      if (fire) m_v = 1'b0;
    end else begin
      if (fire && m_cnt < CMAX) m_cnt++;
      g = -1;
      if (!m_v || fire)
        for (int k = 0; k < W; k++)
          if (g < 0 && m_pend[(m_ptr + k) % W]) g = (m_ptr + k) % W;
      if (g >= 0) begin
        m_pend[g] = 1'b0;
        m_v       = 1'b1;
        exp_q.push_back(longint'(CI + g));
        m_ptr     = (g + 1) % W;
      end else if (fire) begin
        m_v = 1'b0;
      end
      for (int i = 0; i < W; i++)
        if (nb[i]) begin
          m_pend[i] = 1'b1;
          m_seen[i] = 1'b1;
        end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle after it.
  task automatic cyc(input logic [W-1:0] v, input logic e, input logic c, input logic r);
    tv            = v;
    en_r          = e;
    clear_r       = c;
    bus.out_ready = r;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && busy; i++) cyc('0, 1'b1, 1'b0, 1'b1);
    check(name, busy, 0);
  endtask

  // Monitor: compares presented/transferred beats against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      check("out_valid", bus.out_valid, m_v);
      check("busy", busy, m_busy());
      check("hit_count", hit_count, m_cnt);
      if (bus.out_valid && bus.out_ready) begin
        nbeats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.out_index, -1);
        end else begin
          check("beat_index", bus.out_index, exp_q.pop_front());
        end
      end
    end
  end

  int base;

  initial begin
    reset = 1'b1;
    tv = '0; en_r = 1'b0; clear_r = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_hit_count", hit_count, 0);
    #9 reset = 1'b0;
    @(posedge clock); #1;

    // Single hit on bit 5
    base = nbeats;
    cyc(W'(1) << 5, 1'b1, 1'b0, 1'b1);
    drain("single_drain");
    check("single_beats", nbeats - base, 1);
    check("single_count", hit_count, 1);

    // All bits in one cycle
    cyc('0, 1'b1, 1'b1, 1'b1);
    base = nbeats;
    cyc('1, 1'b1, 1'b0, 1'b1);
    drain("all_drain");
    check("all_beats", nbeats - base, W);
    check("all_count", hit_count, W);

    // Backpressure: bits 1 and 3, consumer stalls for ten cycles
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc(W'(4'b1010), 1'b1, 1'b0, 1'b0);
    repeat (11) cyc('0, 1'b1, 1'b0, 1'b0);
    check("bp_held_index", bus.out_index, CI + 1);
    drain("bp_drain");
    check("bp_count", hit_count, 2);

    // Bit 3 held high for 20 cycles
    cyc('0, 1'b1, 1'b1, 1'b1);
    base = nbeats;
    repeat (20) cyc(W'(1) << 3, 1'b1, 1'b0, 1'b1);
    drain("hold_drain");
    check("hold_beats", nbeats - base, STICKY ? 1 : 20);

    // Bits 0 and 34 held high: round-robin alternation
    cyc('0, 1'b1, 1'b1, 1'b1);
    repeat (12) cyc((W'(1) << (W - 1)) | W'(1), 1'b1, 1'b0, 1'b1);
    drain("rr_drain");

    // Saturation of hit_count
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc('1, 1'b1, 1'b0, 1'b1);
    drain("sat_drain1");
    cyc('0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc('1, 1'b1, 1'b0, 1'b1);
      repeat (W + 3) cyc('0, 1'b1, 1'b0, 1'b1);
    end
    drain("sat_drain2");
    check("sat_count", hit_count, STICKY ? W : CMAX);

    // Clear while a beat is held: the beat still fires
    cyc('0, 1'b1, 1'b1, 1'b1);
    cyc(W'(7), 1'b1, 1'b0, 1'b0);
    repeat (3) cyc('0, 1'b1, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b1, 1'b0);
    cyc('0, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0, 1'b1);
    check("clear_busy", busy, 0);
    check("clear_count", hit_count, 1);

    // Async reset mid-drain with a beat presented
    cyc('1, 1'b1, 1'b0, 1'b1);
    repeat (4) cyc('0, 1'b1, 1'b0, 1'b1);
    check("pre_reset_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("areset_out_valid", bus.out_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_count", hit_count, 0);
    #3 reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] rv;
      rv = W'({$urandom(), $urandom()}) & W'({$urandom(), $urandom()}) & W'({$urandom(), $urandom()});
      cyc(rv, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7));
    end
    drain("rand_drain");
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_cover_sched.md
# toggle_cover_sched

Serializing scheduler for toggle-coverage hit vectors. It accumulates per-bit hit pulses from one coverage group into a pending bitmap. A round-robin arbiter drains them as one absolute cover index per beat over a valid/ready port. It sits between a toggle-coverage group and the single-channel coverage reporter (DPI shim or formal cover sink), so that a multi-bit group no longer needs one report call per bit per cycle.

## Interface
- `WIDTH`, 35, number of cover bits in the group.
- `COVER_INDEX`, 0, absolute index of bit 0; emitted index = `COVER_INDEX` + bit number.
- `CNT_W`, 32, width of `hit_count`.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `valid`  in  `WIDTH`  per-bit hit pulses for the current cycle.
- `en`  in  1  sampling enable; when low, `valid` is ignored. Draining continues.
- `clear`  in  1  synchronous clear of pending/seen/pointer/counter.
- `out_valid`  out  1  a cover index is presented.
- `out_ready`  in  1  consumer accepts; a beat transfers when `out_valid && out_ready`.
- `out_index`  out  64  absolute cover index of the presented beat.
- `busy`  out  1  `|pending || out_valid`.
- `hit_count`  out  `CNT_W`  number of beats transferred, saturating at all-ones.

## Operation
- State:
  - `pending[WIDTH]`: bits awaiting report.
  - `seen[WIDTH]`: sticky mode only.
  - `ptr`: round-robin start, range 0..`WIDTH`-1.
  - Output register: `out_valid`, `out_index`.
  - `hit_count`.
- Sample term: `new = en ? valid (& ~seen when sticky) : 0`.
- Arbiter (combinational on registered `pending`):
  - Selects the first set bit at position >= `ptr`, wrapping past `WIDTH`-1 to 0.
  - Grant is taken only when the output register is empty or fires this cycle.
- On grant g:
  - `out_index <= COVER_INDEX + g`, zero-extended to 64 bits.
  - `out_valid <= 1`.
  - `pending[g]` cleared.
  - `ptr <= (g == WIDTH-1) ? 0 : g+1`.
- Fire with no grant: `out_valid <= 0`.
- No fire with `out_valid` high: output holds; `out_index` must not change.
- Pending update: `pending <= (pending & ~grant_onehot) | new`. If `new` sets a bit in the same cycle it is granted, the set wins and the bit stays pending.
- `hit_count` increments by 1 on each fire and saturates; it never wraps.
- `clear` (priority over sampling):
  - Zeros `pending`, `seen`, `ptr` and `hit_count`.
  - `valid` that cycle is discarded.
  - A presented beat (`out_valid` high) is kept until it fires; no grant is issued in the clear cycle.
- Reset values: `pending`=0, `seen`=0, `ptr`=0, `out_valid`=0, `out_index`=0, `hit_count`=0, so `busy`=0.
- Reset asserted mid-operation: all state is discarded immediately, including a presented beat.

## Timing
- Latency: `valid[i]` high in cycle 0 -> `pending[i]` set at the end of cycle 0 -> granted in cycle 1 -> `out_valid`/`out_index` visible in cycle 2.
- Throughput: 1 beat/cycle while `out_ready` stays high and `pending` is non-zero.
- `out_valid`, once high, stays high with a stable `out_index` until the beat fires.
- All outputs are registered except `busy`, which is combinational from registers.
- Worst-case drain of a full bitmap: `WIDTH` beats, starting 2 cycles after sampling.

## Configuration
- `TOGGLE_COVER_STICKY_EN` defined:
  - `seen[i]` is set when bit i enters `pending`, and later `valid[i]` is masked.
  - Each bit is reported at most once between resets/clears.
  - `hit_count` equals the number of distinct bits reported.
- Not defined:
  - `seen` is not implemented.
  - A bit re-enters `pending` on every asserted sample.
  - Continuously high bits are reported repeatedly, arbitrated round-robin.

## Test plan
- Single hit, `COVER_INDEX`=100: `valid`=1<<5 for one cycle with `out_ready`=1 -> exactly one beat in cycle 2, `out_index`=105; `busy` low in cycle 3; `hit_count`=1.
- All bits, one cycle: `valid`=all-ones, `out_ready`=1 -> 35 consecutive beats with indices 0..34 ascending, no gaps; `hit_count`=35.
- Backpressure:
  - Stimulus: `valid`=0b1010 for one cycle; `out_ready`=0 for cycles 2-11, then 1.
  - Cycles 2-11: `out_index`=1 held stable.
  - Cycle 12: fires index 1.
  - Cycle 13: index 3 follows.
  - No beats lost.
- Sticky versus non-sticky: bit 3 held high for 20 cycles with `out_ready`=1.
  - With `TOGGLE_COVER_STICKY_EN`: exactly one beat (3).
  - Without it: 20 beats of index 3, one per cycle from cycle 2.
- Round-robin, non-sticky: bits 0 and 34 held high, `out_ready`=1 -> beat sequence 0, 34, 0, 34, … strictly alternating.
- Reset and clear:
  - Async `reset` pulse mid-drain while `out_valid`=1 -> `out_valid`=0 before the next edge, `pending`=0, `hit_count`=0.
  - `clear` with a held beat -> beat still fires, then `busy`=0.
